// File: rtl/mmio_pkg.sv
// Shared MMIO constants for the seven-segment/LED output block: register offsets,
// CTRL reset value, hex7 segment table and the CTRL register layout.
package mmio_pkg;

  localparam logic [3:0] SEG_LED_OFF  = 4'h0;
  localparam logic [3:0] SEG_DIG_OFF  = 4'h4;
  localparam logic [3:0] SEG_CTRL_OFF = 4'h8;

  localparam logic [31:0] CTRL_RESET = 32'h0000_00FF;

  localparam int unsigned DIG_IDX_W = 3;
  localparam int unsigned CTRL_W    = 16;

  // Active-high segments in gfedcba order
  localparam logic [6:0] HEX7_0 = 7'h3F;
  localparam logic [6:0] HEX7_1 = 7'h06;
  localparam logic [6:0] HEX7_2 = 7'h5B;
  localparam logic [6:0] HEX7_3 = 7'h4F;
  localparam logic [6:0] HEX7_4 = 7'h66;
  localparam logic [6:0] HEX7_5 = 7'h6D;
  localparam logic [6:0] HEX7_6 = 7'h7D;
  localparam logic [6:0] HEX7_7 = 7'h07;
  localparam logic [6:0] HEX7_8 = 7'h7F;
  localparam logic [6:0] HEX7_9 = 7'h6F;
  localparam logic [6:0] HEX7_A = 7'h77;
  localparam logic [6:0] HEX7_B = 7'h7C;
  localparam logic [6:0] HEX7_C = 7'h39;
  localparam logic [6:0] HEX7_D = 7'h5E;
  localparam logic [6:0] HEX7_E = 7'h79;
  localparam logic [6:0] HEX7_F = 7'h71;

  localparam logic [15:0][6:0] HEX7_TABLE = {
    HEX7_F, HEX7_E, HEX7_D, HEX7_C, HEX7_B, HEX7_A, HEX7_9, HEX7_8,
    HEX7_7, HEX7_6, HEX7_5, HEX7_4, HEX7_3, HEX7_2, HEX7_1, HEX7_0
  };

  typedef struct packed {
    logic [7:0] dp;  // decimal point per digit
    logic [7:0] en;  // digit enable per digit
  } ctrl_t;

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to active-high gfedcba seven-segment pattern.
module hex7_decode
  import mmio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = HEX7_TABLE[nibble];
  end

endmodule

// File: rtl/mmio_seg_led_out.sv
// MMIO output peripheral: LED register plus 8-digit multiplexed seven-segment display.
// Optional registered readback on rdata when MMIO_READBACK_EN is defined.
module mmio_seg_led_out
  import mmio_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned LED_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  output logic [7:0]       seg_n,
  output logic [7:0]       an_n
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]     scan_cnt;
  logic [DIG_IDX_W-1:0] dig_idx;
  logic [31:0]          digits_reg;
  ctrl_t                ctrl_reg;

  logic                 scan_wrap_c;
  logic [3:0]           nibble_c;
  logic [6:0]           hex_seg_c;
  logic [7:0]           seg_nxt_c;
  logic [7:0]           an_nxt_c;

  // Register file; led is the LED register itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= '0;
      digits_reg <= '0;
      ctrl_reg   <= ctrl_t'(CTRL_RESET[CTRL_W-1:0]);
    end else if (we) begin
      case (addr)
        SEG_LED_OFF:  led        <= wdata[LED_W-1:0];
        SEG_DIG_OFF:  digits_reg <= wdata;
        SEG_CTRL_OFF: ctrl_reg   <= ctrl_t'(wdata[CTRL_W-1:0]);
        default: ;
      endcase
    end
  end

  // Free-running slot timer and digit index
  always_comb begin
    scan_wrap_c = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_wrap_c) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + DIG_IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nibble_c = digits_reg[{dig_idx, 2'b00} +: 4];
  end

  hex7_decode u_hex7 (
    .nibble (nibble_c),
    .seg_c  (hex_seg_c)
  );

  // Next display drive: blank unless the current digit is enabled
  always_comb begin
    seg_nxt_c = 8'hFF;
    an_nxt_c  = 8'hFF;
    if (ctrl_reg.en[dig_idx]) begin
      an_nxt_c  = ~(8'h01 << dig_idx);
      seg_nxt_c = {~ctrl_reg.dp[dig_idx], ~hex_seg_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 8'hFF;
      an_n  <= 8'hFF;
    end else begin
      seg_n <= seg_nxt_c;
      an_n  <= an_nxt_c;
    end
  end

`ifdef MMIO_READBACK_EN
  // Read returns pre-write contents when a write hits the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      case (addr)
        SEG_LED_OFF:  rdata <= 32'(led);
        SEG_DIG_OFF:  rdata <= digits_reg;
        SEG_CTRL_OFF: rdata <= 32'(ctrl_reg);
        default:      rdata <= '0;
      endcase
    end
  end
`else
  assign rdata = '0;
`endif

endmodule

// File: tb/tb_mmio_seg_led_out.sv
// Self-checking bench for mmio_seg_led_out with SCAN_DIV = 4, randomized writes
// checked against a time-based reference model.
module tb_mmio_seg_led_out;

  localparam int unsigned SDIV = 4;
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h8;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [23:0] led;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;

  int checks = 0;
  int failures = 0;

  mmio_seg_led_out #(.SCAN_DIV(SDIV), .LED_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .led   (led),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  always #5 clk = ~clk;

  // Reference model: digit shown after edge n is determined by edges elapsed since reset
  int unsigned edges;
  int unsigned m_d;
  logic [3:0]  m_nib;
  logic [23:0] m_led;
  logic [31:0] m_dig;
  logic [15:0] m_ctrl;
  logic [23:0] exp_led;
  logic [7:0]  exp_seg, exp_an;
  logic [31:0] exp_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges = 0; m_led = '0; m_dig = '0; m_ctrl = 16'h00FF;
      exp_led = '0; exp_seg = 8'hFF; exp_an = 8'hFF; exp_rd = '0;
    end else begin
      m_d = (edges / SDIV) % 8;
      exp_an = 8'hFF; exp_seg = 8'hFF;
      if (m_ctrl[m_d]) begin
        exp_an  = ~(8'h01 << m_d);
        m_nib   = m_dig[m_d*4 +: 4];
        exp_seg = {~m_ctrl[8+m_d], ~HEX_TAB[m_nib]};
      end
`ifdef MMIO_READBACK_EN
      if (addr == 4'h0) exp_rd = {8'h00, m_led};
      else if (addr == 4'h4) exp_rd = m_dig;
      else if (addr == 4'h8) exp_rd = {16'h0000, m_ctrl};
      else exp_rd = '0;
`else
      exp_rd = '0;
`endif
      if (we) begin
        if (addr == 4'h0) m_led = wdata[23:0];
        else if (addr == 4'h4) m_dig = wdata;
        else if (addr == 4'h8) m_ctrl = wdata[15:0];
      end
      exp_led = m_led;
      edges++;
    end
  end

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; addr = 4'h8;
    repeat (3) @(negedge clk);
    checks++; if (led !== 24'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led); end
    checks++; if (seg_n !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", seg_n); end
    checks++; if (an_n !== 8'hFF) begin failures++; $display("FAIL reset_an got=%h exp=ff", an_n); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an_n !== 8'hFE) begin failures++; $display("FAIL release_an got=%h exp=fe", an_n); end
    checks++; if (seg_n !== 8'hC0) begin failures++; $display("FAIL release_seg got=%h exp=c0", seg_n); end
`ifdef MMIO_READBACK_EN
    checks++; if (rdata !== 32'h0000_00FF) begin failures++; $display("FAIL reset_ctrl_read got=%h exp=000000ff", rdata); end
`else
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rdata_const got=%h exp=0", rdata); end
`endif
  endtask

  task automatic test_led_write();
    logic [31:0] d;
    do_write(4'h0, 32'h00AB_CDEF);
    checks++; if (led !== 24'hABCDEF) begin failures++; $display("FAIL led_write got=%h exp=abcdef", led); end
    do_write(4'hC, $urandom);
    repeat (2) @(negedge clk);
    checks++; if (led !== 24'hABCDEF) begin failures++; $display("FAIL led_unmapped got=%h exp=abcdef", led); end
    checks++; if (seg_n !== exp_seg || an_n !== exp_an) begin
      failures++; $display("FAIL unmapped_display got=%h/%h exp=%h/%h", seg_n, an_n, exp_seg, exp_an);
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      do_write(4'h0, d);
      checks++; if (led !== d[23:0] || led !== exp_led) begin
        failures++; $display("FAIL led_rand got=%h exp=%h", led, d[23:0]);
      end
    end
  endtask

  task automatic align_digit(input logic [7:0] target);
    logic [7:0] prev;
    int n;
    n = 0;
    prev = an_n;
    @(negedge clk);
    while (!(an_n == target && prev != target) && n < 100) begin
      prev = an_n; n++;
      @(negedge clk);
    end
    checks++; if (n >= 100) begin failures++; $display("FAIL align_timeout got=%h exp=%h", an_n, target); end
  endtask

  task automatic test_scan();
    do_write(4'h4, 32'h7654_3210);
    do_write(4'h8, 32'h0000_00FF);
    align_digit(8'hFE);
    for (int j = 0; j < 32; j++) begin
      checks++; if (an_n !== ~(8'h01 << (j / 4))) begin
        failures++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", j, an_n, ~(8'h01 << (j / 4)));
      end
      checks++; if (seg_n !== {1'b1, ~HEX_TAB[j / 4]} || seg_n !== exp_seg) begin
        failures++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", j, seg_n, {1'b1, ~HEX_TAB[j / 4]});
      end
      checks++; if ($countones(~an_n) != 1) begin
        failures++; $display("FAIL scan_onehot got=%h exp=one_low", an_n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ctrl_mask();
    int seen0, seen2;
    seen0 = 0; seen2 = 0;
    do_write(4'h8, 32'h0000_0105);
    @(negedge clk);
    for (int j = 0; j < 40; j++) begin
      checks++; if (an_n !== exp_an || seg_n !== exp_seg) begin
        failures++; $display("FAIL mask_model got=%h/%h exp=%h/%h", an_n, seg_n, exp_an, exp_seg);
      end
      if (an_n == 8'hFE) begin
        seen0++;
        checks++; if (seg_n[7] !== 1'b0) begin failures++; $display("FAIL mask_dp0 got=%b exp=0", seg_n[7]); end
      end else if (an_n == 8'hFB) begin
        seen2++;
        checks++; if (seg_n[7] !== 1'b1) begin failures++; $display("FAIL mask_dp2 got=%b exp=1", seg_n[7]); end
      end else begin
        checks++; if (an_n !== 8'hFF || seg_n !== 8'hFF) begin
          failures++; $display("FAIL mask_blank got=%h/%h exp=ff/ff", an_n, seg_n);
        end
      end
      @(negedge clk);
    end
    checks++; if (seen0 == 0 || seen2 == 0) begin
      failures++; $display("FAIL mask_seen got=%0d/%0d exp=nonzero", seen0, seen2);
    end
  endtask

  task automatic test_random();
    logic [3:0] a;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: a = 4'h0;
        1: a = 4'h4;
        2: a = 4'h8;
        3: a = 4'hC;
        default: a = 4'($urandom);
      endcase
      we = ($urandom_range(0, 2) == 0); addr = a; wdata = $urandom;
      @(negedge clk);
      checks++; if (led !== exp_led || an_n !== exp_an || seg_n !== exp_seg || rdata !== exp_rd) begin
        failures++;
        $display("FAIL rand_cyc%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", i,
                 led, an_n, seg_n, rdata, exp_led, exp_an, exp_seg, exp_rd);
      end
      checks++; if ($countones(~an_n) > 1) begin failures++; $display("FAIL rand_onehot got=%h exp=le1_low", an_n); end
    end
    we = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int idx;
    a = $urandom; b = $urandom;
    do_write(4'h8, 32'h0000_00FF);
    we = 1'b1; addr = 4'h4; wdata = a;
    @(negedge clk);
    wdata = b;
    @(negedge clk);
    we = 1'b0;
`ifdef MMIO_READBACK_EN
    @(negedge clk);
    checks++; if (rdata !== b) begin failures++; $display("FAIL b2b_read got=%h exp=%h", rdata, b); end
`endif
    @(negedge clk);
    for (int j = 0; j < 32; j++) begin
      idx = 0;
      for (int k = 0; k < 8; k++) if (an_n[k] == 1'b0) idx = k;
      checks++; if (seg_n[6:0] !== ~HEX_TAB[b[idx*4 +: 4]]) begin
        failures++; $display("FAIL b2b_seg dig=%0d got=%h exp=%h", idx, seg_n[6:0], ~HEX_TAB[b[idx*4 +: 4]]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_write(4'h0, 32'h0012_3456);
    do_write(4'h4, 32'h89AB_CDEF);
    align_digit(8'hDF);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (led !== 24'h0 || seg_n !== 8'hFF || an_n !== 8'hFF || rdata !== 32'h0) begin
      failures++; $display("FAIL async_reset got=%h/%h/%h/%h exp=0/ff/ff/0", led, seg_n, an_n, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an_n !== 8'hFE || seg_n !== 8'hC0) begin
      failures++; $display("FAIL async_restart got=%h/%h exp=fe/c0", an_n, seg_n);
    end
  endtask

  task automatic test_readback();
`ifdef MMIO_READBACK_EN
    do_write(4'h4, 32'hDEAD_BEEF);
    addr = 4'h4;
    @(negedge clk);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_digits got=%h exp=deadbeef", rdata); end
    addr = 4'h2;
    @(negedge clk);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL read_unmapped got=%h exp=0", rdata); end
    do_write(4'h0, 32'h0000_1111);
    do_write(4'h0, 32'h0000_2222);
    checks++; if (rdata !== 32'h0000_1111) begin failures++; $display("FAIL read_old got=%h exp=00001111", rdata); end
    addr = 4'h8;
    do_write(4'h8, 32'hFFFF_0F0F);
    @(negedge clk);
    checks++; if (rdata !== 32'h0000_0F0F) begin failures++; $display("FAIL read_ctrl got=%h exp=00000f0f", rdata); end
`else
    for (int i = 0; i < 6; i++) begin
      do_write(4'(i * 4 % 12), $urandom);
      checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL rdata_zero got=%h exp=0", rdata); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_led_write();
    test_scan();
    test_ctrl_mask();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_readback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
